ahb_slave_if: RTL and testbench
===============================

// Module: ahb_slave_if
// PURPOSE
//  AHB-lite responder front-end of the AHB-to-APB bridge: decodes address/data phases from the AHB master,
//  answers with hreadyout/hresp/hrdata, and queues accepted transfers into an in-order request FIFO
//  consumed by the APB-side controller via valid/ready. Read data returns from the APB side on rsp_valid.
// PARAMETERS
//  ADDR_LO     32'h8000_0000  inclusive lower bound of bridge address window
//  ADDR_HI     32'h8C00_0000  exclusive upper bound of bridge address window
//  FIFO_DEPTH  4              request FIFO entries (power of 2, >=2)
// PORTS
//  hclk       in   1   clock, all logic on rising edge
//  hreset     in   1   synchronous reset, active-high
//  haddr      in   32  AHB address (address phase)
//  htrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite     in   1   1=write, 0=read (address phase)
//  hreadyin   in   1   bus-level ready; transfer sampled only when 1
//  hwdata     in   32  write data (data phase)
//  hreadyout  out  1   slave ready; 0 extends data phase
//  hresp      out  2   00 OKAY, 01 ERROR
//  hrdata     out  32  read data, valid when hreadyout=1 after a read
//  req_valid  out  1   FIFO head valid (= !empty)
//  req_ready  in   1   APB side accepts head; pop when req_valid&&req_ready
//  req_addr   out  32  head address
//  req_write  out  1   head direction
//  req_wdata  out  32  head write data (0 for reads)
//  rsp_valid  in   1   read data from APB side valid, one-cycle pulse
//  rsp_rdata  in   32  read data
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, hreadyout=1, hresp=00, hrdata=0, req_valid=0, addr/write latches=0.
//  Accept = hreadyin && htrans[1] && hreadyout, evaluated in IDLE, WDATA(not stalled), RDONE, ERR2.
//   IDLE/BUSY htrans ignored. Hit = ADDR_LO <= haddr < ADDR_HI.
//  On accept: miss -> ERR1 (no push); hit&write -> latch haddr, WDATA; hit&read -> latch haddr, RREQ.
//  No accept in IDLE/RDONE/ERR2/WDATA-complete -> IDLE.
//  hreadyout/hresp are decoded from state and FIFO count only (no combinational path from AHB inputs):
//   IDLE    : ready=1, OKAY.
//   WDATA   : ready = !full. When !full: push {addr,1,hwdata} this cycle, then accept/IDLE.
//             When full: ready=0, stay; hwdata held by master, sampled on the push cycle.
//   RREQ    : ready=0; push {addr,0,0} when !full -> RWAIT.
//   RWAIT   : ready=0; on rsp_valid: hrdata<=rsp_rdata -> RDONE. Reads complete only after all older
//             FIFO entries (strict order through FIFO).
//   RDONE   : ready=1, OKAY, hrdata holds captured value until next read completes.
//   ERR1    : ready=0, hresp=01 -> ERR2.   ERR2: ready=1, hresp=01 (two-cycle AHB error).
//  FIFO: full when count==FIFO_DEPTH. Push blocked when full even if pop same cycle (no pass-through).
//   Push+pop same cycle (not full) -> count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  rsp_valid outside RWAIT is ignored. hreset mid-transfer: FIFO flushed, pending read abandoned, state IDLE
//   next cycle; downstream must tolerate loss of in-flight req.
//  Back-to-back pipelined accepts sustain 1 write per cycle while FIFO has space.
// TESTING
//  1 Single write 0x8000_0001, data 0x80, req_ready=1 -> one pop {0x8000_0001,1,0x80}; hreadyout never 0.
//  2 Single read 0x8000_0001, rsp_valid 3 cycles after pop with 0xA5 -> hreadyout 0 through RWAIT,
//    then hrdata=0x0000_00A5 with hreadyout=1, hresp=00.
//  3 INCR writes 0x8000_0000..0x8000_0004 (5 beats), req_ready=0 -> 4 entries queued, 5th data phase
//    hreadyout=0; raise req_ready -> 5th pushed, pops in address order 00..04.
//  4 Write to 0x7000_0000 -> hresp=01 for 2 cycles (hreadyout 0 then 1), req_valid stays 0.
//  5 Write 0x8000_0000=0x5A then read 0x8000_0000 back-to-back -> pops write then read; read completes
//    only after its own rsp_valid.
//  6 hreset during RWAIT with 2 queued -> next cycle hreadyout=1, req_valid=0; later rsp_valid ignored.

Source files
------------

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-lite responder front-end that queues bridge-window transfers into an in-order request FIFO.
module ahb_slave_if #(
  parameter logic [31:0] ADDR_LO    = 32'h8000_0000,
  parameter logic [31:0] ADDR_HI    = 32'h8C00_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_write,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, WDATA, RREQ, RWAIT, RDONE, ERR1, ERR2} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } entry_t;
  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic          full, hit, accept, push, pop, unused_trans;
  assign unused_trans = htrans[0];
  assign full   = count_q == CW'(FIFO_DEPTH);
  assign hit    = haddr >= ADDR_LO && haddr < ADDR_HI;
  assign accept = hreadyin && htrans[1] && hreadyout;
  assign push   = !full && (state_q == WDATA || state_q == RREQ);
  assign pop    = req_valid && req_ready;
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      hrdata_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hrdata_q <= hrdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge hclk) mem_q <= mem_d;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (accept) begin
      state_d = !hit ? ERR1 : hwrite ? WDATA : RREQ;
      addr_d  = hit ? haddr : addr_q;
    end else begin
      case (state_q)
        WDATA:   state_d = full ? WDATA : IDLE;
        RREQ:    state_d = full ? RREQ : RWAIT;
        RWAIT:   state_d = rsp_valid ? RDONE : RWAIT;
        ERR1:    state_d = ERR2;
        default: state_d = IDLE;
      endcase
    end
  end
  // Push is refused while full even if a pop happens the same cycle.
  always_comb begin
    mem_d    = mem_q;
    hrdata_d = (state_q == RWAIT && rsp_valid) ? rsp_rdata : hrdata_q;
    if (push)
      mem_d[wr_ptr_q] = '{addr: addr_q, write: state_q == WDATA, wdata: state_q == WDATA ? hwdata : 32'h0};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end
  always_comb begin
    hreadyout = (state_q inside {IDLE, RDONE, ERR2}) || (state_q == WDATA && !full);
    hresp     = (state_q == ERR1 || state_q == ERR2) ? 2'b01 : 2'b00;
    hrdata    = hrdata_q;
    req_valid = count_q != '0;
    req_addr  = mem_q[rd_ptr_q].addr;
    req_write = mem_q[rd_ptr_q].write;
    req_wdata = mem_q[rd_ptr_q].wdata;
  end
endmodule

// File: tb/tb_ahb_slave_if.sv
// tb_ahb_slave_if: table-driven and directed checks of the AHB bridge front-end.
module tb_ahb_slave_if;
  logic        hclk = 1'b0;
  logic        hreset, hwrite, hreadyin, req_ready, rsp_valid;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, rsp_rdata;
  logic        hreadyout, req_valid, req_write;
  logic [1:0]  hresp;
  logic [31:0] hrdata, req_addr, req_wdata;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] htrans, hwrite, haddr, hwdata, req_ready;
    logic [31:0] e_rdy, e_resp, e_rv, e_addr, e_w, e_wd;
  } vec_t;
  vec_t tbl [17];
  ahb_slave_if dut (
    .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hreadyin(hreadyin), .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );
  always #5 hclk = ~hclk;
  task automatic step();
    @(posedge hclk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drv(input logic [1:0] t, input logic w, input logic [31:0] a, input logic [31:0] d);
    htrans = t;
    hwrite = w;
    haddr  = a;
    hwdata = d;
  endtask
  task automatic chk_head(input string name, input logic [31:0] a, input logic w, input logic [31:0] d);
    chk({name, "_rv"}, {31'b0, req_valid}, 32'd1);
    chk({name, "_addr"}, req_addr, a);
    chk({name, "_write"}, {31'b0, req_write}, {31'b0, w});
    chk({name, "_wdata"}, req_wdata, d);
  endtask
  initial begin
    hreset = 1'b1; hreadyin = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    drv(2'b00, 1'b0, 32'h0, 32'h0);
    // single write, error response, then a 5-beat burst stalled on a full FIFO
    tbl[0]  = '{2, 1, 32'h8000_0001, 0,     1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0,             32'h80, 1, 1, 0, 1, 32'h8000_0001, 1, 32'h80};
    tbl[2]  = '{0, 0, 0,             0,     1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{2, 1, 32'h7000_0000, 0,     1, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0,             0,     1, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0,             0,     1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{2, 1, 32'h8000_0000, 0,     0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{3, 1, 32'h8000_0001, 32'h10, 0, 1, 0, 1, 32'h8000_0000, 1, 32'h10};
    tbl[8]  = '{3, 1, 32'h8000_0002, 32'h11, 0, 1, 0, 1, 32'h8000_0000, 1, 32'h10};
    tbl[9]  = '{3, 1, 32'h8000_0003, 32'h12, 0, 1, 0, 1, 32'h8000_0000, 1, 32'h10};
    tbl[10] = '{3, 1, 32'h8000_0004, 32'h13, 0, 0, 0, 1, 32'h8000_0000, 1, 32'h10};
    tbl[11] = '{0, 0, 0,             32'h14, 0, 0, 0, 1, 32'h8000_0000, 1, 32'h10};
    tbl[12] = '{0, 0, 0,             32'h14, 1, 1, 0, 1, 32'h8000_0001, 1, 32'h11};
    tbl[13] = '{0, 0, 0,             32'h14, 1, 1, 0, 1, 32'h8000_0002, 1, 32'h12};
    tbl[14] = '{0, 0, 0,             0,     1, 1, 0, 1, 32'h8000_0003, 1, 32'h13};
    tbl[15] = '{0, 0, 0,             0,     1, 1, 0, 1, 32'h8000_0004, 1, 32'h14};
    tbl[16] = '{0, 0, 0,             0,     1, 1, 0, 0, 0, 0, 0};
    step(); step();
    hreset = 1'b0;
    chk("rst_rdy", {31'b0, hreadyout}, 32'd1);
    chk("rst_resp", {30'b0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_rv", {31'b0, req_valid}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      drv(tbl[i].htrans[1:0], tbl[i].hwrite[0], tbl[i].haddr, tbl[i].hwdata);
      req_ready = tbl[i].req_ready[0];
      step();
      chk($sformatf("v%0d_rdy", i), {31'b0, hreadyout}, tbl[i].e_rdy);
      chk($sformatf("v%0d_resp", i), {30'b0, hresp}, tbl[i].e_resp);
      chk($sformatf("v%0d_rv", i), {31'b0, req_valid}, tbl[i].e_rv);
      if (tbl[i].e_rv[0]) begin
        chk($sformatf("v%0d_addr", i), req_addr, tbl[i].e_addr);
        chk($sformatf("v%0d_write", i), {31'b0, req_write}, tbl[i].e_w);
        chk($sformatf("v%0d_wdata", i), req_wdata, tbl[i].e_wd);
      end
    end
    // single read with delayed response
    req_ready = 1'b1;
    drv(2'b10, 1'b0, 32'h8000_0001, 32'h0);
    step();
    chk("rd_areq_rdy", {31'b0, hreadyout}, 32'd0);
    drv(2'b00, 1'b0, 32'h0, 32'h0);
    step();
    chk("rd_push_rdy", {31'b0, hreadyout}, 32'd0);
    chk_head("rd_push", 32'h8000_0001, 1'b0, 32'h0);
    step();
    chk("rd_pop_rv", {31'b0, req_valid}, 32'd0);
    chk("rd_pop_rdy", {31'b0, hreadyout}, 32'd0);
    step(); step();
    chk("rd_wait_rdy", {31'b0, hreadyout}, 32'd0);
    rsp_valid = 1'b1; rsp_rdata = 32'h0000_00A5;
    step();
    rsp_valid = 1'b0;
    chk("rd_done_rdy", {31'b0, hreadyout}, 32'd1);
    chk("rd_done_resp", {30'b0, hresp}, 32'd0);
    chk("rd_done_data", hrdata, 32'h0000_00A5);
    step();
    chk("rd_hold_data", hrdata, 32'h0000_00A5);
    chk("rd_hold_rdy", {31'b0, hreadyout}, 32'd1);
    // write then read back-to-back: FIFO order and read completion on its own response
    req_ready = 1'b0;
    drv(2'b10, 1'b1, 32'h8000_0000, 32'h0);
    step();
    chk("wr_rd_a_rdy", {31'b0, hreadyout}, 32'd1);
    drv(2'b10, 1'b0, 32'h8000_0000, 32'h5A);
    step();
    chk("wr_rd_b_rdy", {31'b0, hreadyout}, 32'd0);
    chk_head("wr_rd_w", 32'h8000_0000, 1'b1, 32'h5A);
    drv(2'b00, 1'b0, 32'h0, 32'h0);
    step();
    chk("wr_rd_c_rdy", {31'b0, hreadyout}, 32'd0);
    req_ready = 1'b1;
    step();
    chk_head("wr_rd_r", 32'h8000_0000, 1'b0, 32'h0);
    chk("wr_rd_d_rdy", {31'b0, hreadyout}, 32'd0);
    step();
    chk("wr_rd_e_rv", {31'b0, req_valid}, 32'd0);
    chk("wr_rd_e_rdy", {31'b0, hreadyout}, 32'd0);
    rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678;
    step();
    rsp_valid = 1'b0;
    chk("wr_rd_done_rdy", {31'b0, hreadyout}, 32'd1);
    chk("wr_rd_done_data", hrdata, 32'h1234_5678);
    req_ready = 1'b0;
    step();
    // reset while waiting on a read with two entries queued
    drv(2'b10, 1'b1, 32'h8000_0010, 32'h0);
    step();
    drv(2'b10, 1'b0, 32'h8000_0014, 32'h77);
    step();
    drv(2'b00, 1'b0, 32'h0, 32'h0);
    step();
    chk("rst_mid_rv", {31'b0, req_valid}, 32'd1);
    chk("rst_mid_rdy", {31'b0, hreadyout}, 32'd0);
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    chk("rst_mid_after_rdy", {31'b0, hreadyout}, 32'd1);
    chk("rst_mid_after_rv", {31'b0, req_valid}, 32'd0);
    chk("rst_mid_after_resp", {30'b0, hresp}, 32'd0);
    chk("rst_mid_after_data", hrdata, 32'd0);
    rsp_valid = 1'b1; rsp_rdata = 32'h0000_DEAD;
    step();
    rsp_valid = 1'b0;
    chk("stale_rsp_rdy", {31'b0, hreadyout}, 32'd1);
    chk("stale_rsp_data", hrdata, 32'd0);
    chk("stale_rsp_rv", {31'b0, req_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
